// File: rtl/tcp_tx_sched_if.sv
// tcp_tx_sched_if: TCP header output stream produced by tcp_tx_sched.
// The master (scheduler) drives the valid flag and every header field. The
// slave (transmit path) drives m_hdr_ready.
interface tcp_tx_sched_if;
    logic        m_hdr_valid;
    logic        m_hdr_ready;
    logic [31:0] m_seq;
    logic [31:0] m_ack_num;
    logic        m_syn;
    logic        m_fin;
    logic        m_rst;
    logic        m_ack;
    logic [15:0] m_window;
    logic [15:0] m_len;
    logic        m_retx;

    modport master (
        output m_hdr_valid, m_seq, m_ack_num, m_syn, m_fin, m_rst, m_ack,
               m_window, m_len, m_retx,
        input  m_hdr_ready
    );

    modport slave (
        input  m_hdr_valid, m_seq, m_ack_num, m_syn, m_fin, m_rst, m_ack,
               m_window, m_len, m_retx,
        output m_hdr_ready
    );
endinterface

// File: rtl/tcp_tx_sched.sv
// tcp_tx_sched: TCP transmit segment scheduler.
// Arbitrates retransmit, control and data requests onto one header stream and
// owns SND.UNA / SND.NXT, allowing only one unacknowledged sequence-consuming
// segment (SYN, FIN or data) at a time.
// Build option TCP_TX_SCHED_RETX_EN adds the retransmission timer, retry
// counter, retransmit store and retx_fail. Without it an outstanding segment
// is released only by a matching ACK, an accepted RST or iss_load.
module tcp_tx_sched #(
    parameter logic [31:0] RTO_CYCLES  = 32'd125000,
    parameter int unsigned MAX_RETRIES = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           iss_load,
    input  logic [31:0]    iss,
    input  logic           ctrl_req_valid,
    output logic           ctrl_req_ready,
    input  logic           ctrl_req_syn,
    input  logic           ctrl_req_fin,
    input  logic           ctrl_req_rst,
    input  logic           ctrl_req_ack,
    input  logic           data_req_valid,
    output logic           data_req_ready,
    input  logic [15:0]    data_req_len,
    input  logic [31:0]    rcv_nxt,
    input  logic [15:0]    rcv_wnd,
    input  logic           ack_in_valid,
    input  logic [31:0]    ack_in_num,
    tcp_tx_sched_if.master hdr,
    output logic [31:0]    snd_una,
    output logic [31:0]    snd_nxt,
    output logic           outstanding,
    output logic           retx_fail
);
    typedef enum logic {HDR_IDLE, HDR_BUSY} hdr_state_t;

    hdr_state_t  state;
    hdr_state_t  state_next;
    logic        retx_take;
    logic        retx_pend;
    logic        give_up;
    logic        ack_match;
    logic        seg_consumes;
    logic [31:0] seg_consumption;
    logic [31:0] st_seq;
    logic        st_syn;
    logic        st_fin;
    logic        st_ack;
    logic [15:0] st_len;

    assign ack_match    = ack_in_valid && outstanding && (ack_in_num == snd_nxt);
    assign seg_consumes = (ctrl_req_ready && (ctrl_req_syn || ctrl_req_fin)) || data_req_ready;
    assign seg_consumption = (data_req_ready ? {16'd0, data_req_len} : 32'd0)
                           + {31'd0, ctrl_req_ready & ctrl_req_syn}
                           + {31'd0, ctrl_req_ready & ctrl_req_fin};
    assign hdr.m_hdr_valid = (state == HDR_BUSY);

    // Header slot state register; reset discards any pending header at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HDR_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration (retransmit > ctrl > data) and header slot next state.
    always_comb begin
        state_next     = state;
        retx_take      = 1'b0;
        ctrl_req_ready = 1'b0;
        data_req_ready = 1'b0;
        if (state == HDR_IDLE && !iss_load) begin
            if (retx_pend) begin
                retx_take = 1'b1;
            end else if (ctrl_req_valid) begin
                ctrl_req_ready = !outstanding || !(ctrl_req_syn || ctrl_req_fin);
            end else if (data_req_valid) begin
                data_req_ready = !outstanding;
            end
        end
        if (state == HDR_IDLE && (retx_take || ctrl_req_ready || data_req_ready)) begin
            state_next = HDR_BUSY;
        end else if (state == HDR_BUSY && hdr.m_hdr_ready) begin
            state_next = HDR_IDLE;
        end
    end

    // Header field register, loaded from the winning requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr.m_seq     <= '0;
            hdr.m_ack_num <= '0;
            hdr.m_syn     <= 1'b0;
            hdr.m_fin     <= 1'b0;
            hdr.m_rst     <= 1'b0;
            hdr.m_ack     <= 1'b0;
            hdr.m_window  <= '0;
            hdr.m_len     <= '0;
            hdr.m_retx    <= 1'b0;
        end else if (retx_take || ctrl_req_ready || data_req_ready) begin
            hdr.m_ack_num <= rcv_nxt;
            hdr.m_window  <= rcv_wnd;
            hdr.m_retx    <= retx_take;
            if (retx_take) begin
                hdr.m_seq <= st_seq;
                hdr.m_syn <= st_syn;
                hdr.m_fin <= st_fin;
                hdr.m_rst <= 1'b0;
                hdr.m_ack <= st_ack;
                hdr.m_len <= st_len;
            end else if (ctrl_req_ready) begin
                hdr.m_seq <= snd_nxt;
                hdr.m_syn <= ctrl_req_syn;
                hdr.m_fin <= ctrl_req_fin;
                hdr.m_rst <= ctrl_req_rst;
                hdr.m_ack <= ctrl_req_ack;
                hdr.m_len <= '0;
            end else begin
                hdr.m_seq <= snd_nxt;
                hdr.m_syn <= 1'b0;
                hdr.m_fin <= 1'b0;
                hdr.m_rst <= 1'b0;
                hdr.m_ack <= 1'b1;
                hdr.m_len <= data_req_len;
            end
        end
    end

    // Send sequence state and the outstanding flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snd_una     <= '0;
            snd_nxt     <= '0;
            outstanding <= 1'b0;
        end else if (iss_load) begin
            snd_una     <= iss;
            snd_nxt     <= iss;
            outstanding <= 1'b0;
        end else begin
            if (ack_match) begin
                snd_una     <= snd_nxt;
                outstanding <= 1'b0;
            end
            if ((ctrl_req_ready && ctrl_req_rst) || give_up) begin
                outstanding <= 1'b0;
            end
            if (seg_consumes) begin
                snd_nxt     <= snd_nxt + seg_consumption;
                outstanding <= 1'b1;
            end
        end
    end

`ifdef TCP_TX_SCHED_RETX_EN
    logic [31:0] timer;
    logic [31:0] retries;
    logic        timeout;

    assign timeout = outstanding && (state == HDR_IDLE) && !retx_pend && !ack_match
                  && !iss_load && (timer == RTO_CYCLES - 32'd1);
    assign give_up = timeout && (retries >= MAX_RETRIES);

    // Retransmission timer, retry counter and copy of the last consuming segment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer     <= '0;
            retries   <= '0;
            retx_pend <= 1'b0;
            retx_fail <= 1'b0;
            st_seq    <= '0;
            st_syn    <= 1'b0;
            st_fin    <= 1'b0;
            st_ack    <= 1'b0;
            st_len    <= '0;
        end else begin
            retx_fail <= give_up;
            if (iss_load) begin
                timer     <= '0;
                retries   <= '0;
                retx_pend <= 1'b0;
            end else if (seg_consumes) begin
                st_seq    <= snd_nxt;
                st_syn    <= ctrl_req_ready & ctrl_req_syn;
                st_fin    <= ctrl_req_ready & ctrl_req_fin;
                st_ack    <= data_req_ready | ctrl_req_ack;
                st_len    <= data_req_ready ? data_req_len : 16'd0;
                timer     <= '0;
                retries   <= '0;
                retx_pend <= 1'b0;
            end else if (retx_take) begin
                timer     <= '0;
                retx_pend <= 1'b0;
            end else if (ack_match || !outstanding) begin
                timer     <= '0;
                retx_pend <= 1'b0;
            end else if (timeout) begin
                timer <= '0;
                if (!give_up) begin
                    retx_pend <= 1'b1;
                    retries   <= retries + 32'd1;
                end
            end else if (state == HDR_IDLE && !retx_pend) begin
                timer <= timer + 32'd1;
            end
        end
    end
`else
    localparam logic [31:0] unused_cfg = RTO_CYCLES ^ 32'(MAX_RETRIES);

    assign retx_pend = 1'b0;
    assign give_up   = 1'b0;
    assign retx_fail = 1'b0;
    assign st_seq    = '0;
    assign st_syn    = 1'b0;
    assign st_fin    = 1'b0;
    assign st_ack    = 1'b0;
    assign st_len    = '0;
`endif
endmodule

// File: tb/tb_tcp_tx_sched.sv
// tb_tcp_tx_sched: scoreboard bench for tcp_tx_sched.
// Expected headers are queued by the stimulus side from a transaction-level
// model of the send sequence state; a monitor checks every presented header
// against the queue head and pops it on handshake.
module tb_tcp_tx_sched;
    localparam logic [31:0] RTO  = 32'd64;
    localparam int unsigned MAXR = 2;

    typedef struct packed {
        logic [31:0] seq;
        logic [31:0] ack_num;
        logic        syn;
        logic        fin;
        logic        rf;
        logic        ak;
        logic [15:0] window;
        logic [15:0] len;
        logic        retx;
    } hdr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iss_load = 1'b0;
    logic [31:0] iss = '0;
    logic        ctrl_req_valid = 1'b0;
    logic        ctrl_req_ready;
    logic        ctrl_req_syn = 1'b0;
    logic        ctrl_req_fin = 1'b0;
    logic        ctrl_req_rst = 1'b0;
    logic        ctrl_req_ack = 1'b0;
    logic        data_req_valid = 1'b0;
    logic        data_req_ready;
    logic [15:0] data_req_len = 16'd1;
    logic [31:0] rcv_nxt = '0;
    logic [15:0] rcv_wnd = '0;
    logic        ack_in_valid = 1'b0;
    logic [31:0] ack_in_num = '0;
    logic [31:0] snd_una;
    logic [31:0] snd_nxt;
    logic        outstanding;
    logic        retx_fail;

    tcp_tx_sched_if hdr ();

    tcp_tx_sched #(.RTO_CYCLES(RTO), .MAX_RETRIES(MAXR)) dut (
        .clk(clk), .rst(rst), .iss_load(iss_load), .iss(iss),
        .ctrl_req_valid(ctrl_req_valid), .ctrl_req_ready(ctrl_req_ready),
        .ctrl_req_syn(ctrl_req_syn), .ctrl_req_fin(ctrl_req_fin),
        .ctrl_req_rst(ctrl_req_rst), .ctrl_req_ack(ctrl_req_ack),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
        .data_req_len(data_req_len), .rcv_nxt(rcv_nxt), .rcv_wnd(rcv_wnd),
        .ack_in_valid(ack_in_valid), .ack_in_num(ack_in_num), .hdr(hdr),
        .snd_una(snd_una), .snd_nxt(snd_nxt), .outstanding(outstanding),
        .retx_fail(retx_fail)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_hs = 0;
    int   fail_seen = 0;
    logic bp_en = 1'b1;
    logic hold_low = 1'b0;
    hdr_t exp_q[$];

    logic [31:0] md_una = '0;
    logic [31:0] md_nxt = '0;
    logic        md_out = 1'b0;
    int          md_fail = 0;
    hdr_t        md_store;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle counter used to place events relative to a header handshake.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Sink side of the header stream: random or forced backpressure.
    initial begin
        hdr.m_hdr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            hdr.m_hdr_ready = hold_low ? 1'b0 : (bp_en ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: compare every presented header against the scoreboard head.
    initial forever begin
        hdr_t e;
        @(negedge clk);
        if (rst) continue;
        if (hdr.m_hdr_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_header: got seq 0x%08h retx %0b expected none",
                         hdr.m_seq, hdr.m_retx);
            end else begin
                e = exp_q[0];
                check32("hdr_seq", hdr.m_seq, e.seq);
                check32("hdr_ack_num", hdr.m_ack_num, e.ack_num);
                check32("hdr_flags_syn_fin_rst_ack_retx",
                        32'({hdr.m_syn, hdr.m_fin, hdr.m_rst, hdr.m_ack, hdr.m_retx}),
                        32'({e.syn, e.fin, e.rf, e.ak, e.retx}));
                check32("hdr_window", 32'(hdr.m_window), 32'(e.window));
                check32("hdr_len", 32'(hdr.m_len), 32'(e.len));
                if (hdr.m_hdr_ready) begin
                    void'(exp_q.pop_front());
                    last_hs = cyc + 1;
                end
            end
        end
        if (retx_fail) fail_seen++;
    end

    task automatic do_iss(input logic [31:0] v);
        iss = v;
        iss_load = 1'b1;
        tick();
        iss_load = 1'b0;
        md_una = v;
        md_nxt = v;
        md_out = 1'b0;
    endtask

    task automatic ack_arrive(input logic [31:0] num);
        ack_in_valid = 1'b1;
        ack_in_num = num;
        tick();
        ack_in_valid = 1'b0;
        if (md_out && num == md_nxt) begin
            md_una = md_nxt;
            md_out = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        check32({tag, "_snd_una"}, snd_una, md_una);
        check32({tag, "_snd_nxt"}, snd_nxt, md_nxt);
        check32({tag, "_outstanding"}, 32'(outstanding), 32'(md_out));
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || hdr.m_hdr_valid) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            $display("[TB] FAIL drain_timeout: got %0d queued headers expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Issue a ctrl request (fl = {syn,fin,rst,ack}) and/or a data request.
    // Expected headers are queued in priority order: ctrl before data.
    task automatic send_reqs(input logic do_c, input logic [3:0] fl, input logic do_d,
                             input logic [15:0] len, input logic with_iss, input logic [31:0] iss_v);
        hdr_t h;
        logic c_pend = do_c;
        logic d_pend = do_d;
        int   n = 0;
        {ctrl_req_syn, ctrl_req_fin, ctrl_req_rst, ctrl_req_ack} = fl;
        data_req_len = len;
        if (with_iss) begin
            iss = iss_v;
            iss_load = 1'b1;
            ctrl_req_valid = do_c;
            data_req_valid = do_d;
            @(negedge clk);
            check32("iss_load_blocks_req", 32'({ctrl_req_ready, data_req_ready}), 32'd0);
            tick();
            iss_load = 1'b0;
            md_una = iss_v;
            md_nxt = iss_v;
            md_out = 1'b0;
        end
        if (do_c) begin
            h = '{seq: md_nxt, ack_num: rcv_nxt, syn: fl[3], fin: fl[2], rf: fl[1], ak: fl[0],
                  window: rcv_wnd, len: 16'd0, retx: 1'b0};
            exp_q.push_back(h);
            if (fl[3] || fl[2]) begin
                md_store = h;
                md_nxt = md_nxt + 32'(fl[3]) + 32'(fl[2]);
                md_out = 1'b1;
            end
            if (fl[1]) md_out = 1'b0;
        end
        if (do_d) begin
            h = '{seq: md_nxt, ack_num: rcv_nxt, syn: 1'b0, fin: 1'b0, rf: 1'b0, ak: 1'b1,
                  window: rcv_wnd, len: len, retx: 1'b0};
            exp_q.push_back(h);
            md_store = h;
            md_nxt = md_nxt + 32'(len);
            md_out = 1'b1;
        end
        ctrl_req_valid = c_pend;
        data_req_valid = d_pend;
        while ((c_pend || d_pend) && n < 300) begin
            @(negedge clk);
            if (ctrl_req_ready) c_pend = 1'b0;
            if (data_req_ready) d_pend = 1'b0;
            tick();
            n++;
            ctrl_req_valid = c_pend;
            data_req_valid = d_pend;
        end
        if (c_pend || d_pend) begin
            n_checks++;
            $display("[TB] FAIL req_accept_timeout: got ctrl/data pending %0b%0b expected 00", c_pend, d_pend);
        end
        ctrl_req_valid = 1'b0;
        data_req_valid = 1'b0;
    endtask

    // While a consuming segment is outstanding, data and FIN must be refused.
    task automatic blocked_probe();
        data_req_len = 16'd10;
        data_req_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check32("data_blocked", 32'(data_req_ready), 32'd0);
            tick();
        end
        data_req_valid = 1'b0;
        {ctrl_req_syn, ctrl_req_fin, ctrl_req_rst, ctrl_req_ack} = 4'b0101;
        ctrl_req_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check32("fin_blocked", 32'(ctrl_req_ready), 32'd0);
            tick();
        end
        ctrl_req_valid = 1'b0;
    endtask

    // Let the outstanding segment go unacknowledged until the scheduler gives up.
    task automatic run_timeout();
        int n = 0;
        hdr_t h;
`ifdef TCP_TX_SCHED_RETX_EN
        h = md_store;
        h.ack_num = rcv_nxt;
        h.window = rcv_wnd;
        h.retx = 1'b1;
        for (int r = 0; r < int'(MAXR); r++) exp_q.push_back(h);
        while (fail_seen < md_fail + 1 && n < 4 * int'(RTO) * (int'(MAXR) + 1)) begin
            tick();
            n++;
        end
        md_fail++;
        md_out = 1'b0;
        check32("retx_fail_pulse", 32'(fail_seen), 32'(md_fail));
        check32("retx_all_sent", 32'(exp_q.size()), 32'd0);
        repeat (2 * int'(RTO)) tick();
        check32("retx_fail_once", 32'(fail_seen), 32'(md_fail));
        check_state("give_up");
`else
        repeat (10 * int'(RTO)) tick();
        check32("no_retx_outstanding", 32'(outstanding), 32'd1);
        check32("no_retx_fail", 32'(fail_seen), 32'd0);
        check_state("no_retx");
        do_iss($urandom);
        check_state("recover_iss");
`endif
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sel;
        int minor;
        int res;
        logic [15:0] len;
        logic [3:0]  fl;

        // Reset values
        repeat (3) @(negedge clk);
        check32("rst_snd_una", snd_una, 32'd0);
        check32("rst_snd_nxt", snd_nxt, 32'd0);
        check32("rst_outstanding_valid_fail",
                32'({outstanding, hdr.m_hdr_valid, retx_fail}), 32'd0);
        check32("rst_hdr_seq", hdr.m_seq, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // iss_load beats a same-cycle SYN; SYN then takes seq 0x1000
        rcv_nxt = 32'h5000_0000;
        rcv_wnd = 16'd4096;
        send_reqs(1'b1, 4'b1000, 1'b0, 16'd0, 1'b1, 32'h0000_1000);
        drain();
        check_state("syn");
        blocked_probe();
        ack_arrive(32'h0000_1005);
        check_state("wrong_ack");
        ack_arrive(32'h0000_1001);
        check_state("syn_acked");

        // Pure ACK and data together: ACK first, data follows
        send_reqs(1'b1, 4'b0001, 1'b1, 16'd100, 1'b0, 32'd0);
        drain();
        check_state("ack_then_data");
        ack_arrive(32'h0000_1065);
        check_state("data_acked");

        // Header held for 10 cycles with ready low
        hold_low = 1'b1;
        send_reqs(1'b1, 4'b0001, 1'b0, 16'd0, 1'b0, 32'd0);
        repeat (10) tick();
        hold_low = 1'b0;
        drain();

        // Sequence wrap
        send_reqs(1'b0, 4'b0000, 1'b1, 16'h0020, 1'b1, 32'hFFFF_FFF0);
        drain();
        check_state("wrap");
        ack_arrive(32'h0000_0010);
        check_state("wrap_acked");

        // Matching ACK in the timeout cycle wins: no retransmission
        bp_en = 1'b0;
        tick();
        send_reqs(1'b0, 4'b0000, 1'b1, 16'd7, 1'b0, 32'd0);
        drain();
        while (cyc < last_hs + int'(RTO) - 1) tick();
        ack_arrive(md_nxt);
        repeat (2 * int'(RTO)) tick();
        check_state("ack_beats_timeout");
        check32("ack_beats_timeout_fail", 32'(fail_seen), 32'(md_fail));
        bp_en = 1'b1;

        // Unacknowledged FIN
        send_reqs(1'b1, 4'b0101, 1'b0, 16'd0, 1'b0, 32'd0);
        drain();
        run_timeout();

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            rcv_nxt = $urandom;
            rcv_wnd = 16'($urandom);
            if ($urandom_range(0, 7) == 0) do_iss(32'hFFFF_FC00 + 32'($urandom_range(0, 1023)));
            sel = $urandom_range(0, 5);
            len = 16'($urandom_range(1, 3000));
            if ($urandom_range(0, 9) == 0) len = 16'hFFFF;
            case (sel)
                0: send_reqs(1'b1, {3'b100, 1'($urandom_range(0, 1))}, 1'b0, 16'd0, 1'b0, 32'd0);
                1: send_reqs(1'b1, 4'b0101, 1'b0, 16'd0, 1'b0, 32'd0);
                2, 3: send_reqs(1'b0, 4'b0000, 1'b1, len, 1'b0, 32'd0);
                4: send_reqs(1'b1, 4'b0001, 1'b0, 16'd0, 1'b0, 32'd0);
                default: send_reqs(1'b1, {3'b001, 1'($urandom_range(0, 1))}, 1'b0, 16'd0, 1'b0, 32'd0);
            endcase
            drain();
            if (md_out) begin
                minor = $urandom_range(0, 3);
                if (minor == 1) ack_arrive(md_nxt + 32'd1);
                if (minor == 2) begin
                    send_reqs(1'b1, 4'b0001, 1'b0, 16'd0, 1'b0, 32'd0);
                    drain();
                end
                if (minor == 3) blocked_probe();
                res = $urandom_range(0, 9);
                if (res == 0) begin
                    run_timeout();
                end else if (res == 1) begin
                    fl = {3'b001, 1'($urandom_range(0, 1))};
                    send_reqs(1'b1, fl, 1'b0, 16'd0, 1'b0, 32'd0);
                    drain();
                end else begin
                    repeat ($urandom_range(0, 3)) tick();
                    ack_arrive(md_nxt);
                end
            end
            check_state("rand");
        end
        check32("total_retx_fail", 32'(fail_seen), 32'(md_fail));

        // Reset while a header is pending
        hold_low = 1'b1;
        send_reqs(1'b1, 4'b0001, 1'b0, 16'd0, 1'b0, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check32("rst_mid_valid", 32'(hdr.m_hdr_valid), 32'd0);
        check32("rst_mid_snd_nxt", snd_nxt, 32'd0);
        check32("rst_mid_outstanding", 32'(outstanding), 32'd0);
        exp_q.delete();
        hold_low = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tcp_tx_sched.md
# tcp_tx_sched

TCP transmit segment scheduler. It sits between the connection state machine / application data source and the TCP transmit path. It arbitrates control-segment and data-segment requests onto one TCP header stream and owns the send sequence state (SND.UNA, SND.NXT). It enforces stop-and-wait for sequence-consuming segments and retransmits on timeout.

## Interface
- `RTO_CYCLES`, default 32'd125000: retransmission timeout, in clk cycles.
- `MAX_RETRIES`, default 3: retransmissions attempted before giving up.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `iss_load`  in  1  pulse: SND.UNA = SND.NXT = `iss`; clears outstanding state, timer and retry count.
- `iss`  in  32  initial send sequence number.
- `ctrl_req_valid` / `ctrl_req_ready`  in/out  1  control segment handshake.
- `ctrl_req_syn`, `ctrl_req_fin`, `ctrl_req_rst`, `ctrl_req_ack`  in  1 each  requested flags.
- `data_req_valid` / `data_req_ready`  in/out  1  data segment handshake.
- `data_req_len`  in  16  payload bytes; must be nonzero.
- `rcv_nxt`  in  32  current RCV.NXT, used as the ack number.
- `rcv_wnd`  in  16  advertised window.
- `ack_in_valid`  in  1  received segment carried ACK.
- `ack_in_num`  in  32  received ack number.
- `m_hdr_valid` / `m_hdr_ready`  out/in  1  header output handshake.
- `m_seq`, `m_ack_num`  out  32  sequence and ack numbers.
- `m_syn`, `m_fin`, `m_rst`, `m_ack`  out  1  flags.
- `m_window`  out  16  window.
- `m_len`  out  16  payload length (0 for control segments).
- `m_retx`  out  1  header is a retransmission.
- `snd_una`, `snd_nxt`  out  32  send sequence state.
- `outstanding`  out  1  an unacknowledged sequence-consuming segment exists.
- `retx_fail`  out  1  one-cycle pulse: retries exhausted.

## Operation
- Sequence-consuming segment: SYN, FIN, or data. Its consumption is `len + syn + fin`, computed mod 2^32.
- Pure ACK and RST segments consume no sequence space and are never retransmitted.
- Arbitration is evaluated only when no header is pending (`m_hdr_valid` = 0). Priority order:
  1. retransmit request;
  2. ctrl request;
  3. data request.
- Eligibility while `outstanding` = 1:
  - data is blocked (`data_req_ready` = 0);
  - ctrl requests with SYN or FIN are blocked;
  - pure ACK and RST requests are allowed.
- `*_req_ready` is asserted combinationally only for the winning, eligible requester.
- On ctrl or data acceptance, the header register loads:
  - `m_seq` = SND.NXT, `m_ack_num` = `rcv_nxt`, `m_window` = `rcv_wnd`;
  - `m_ack` = `ctrl_req_ack` for ctrl; 1 for data.
- If the accepted segment is sequence-consuming:
  - latch its seq, flags and len into the retransmit store;
  - SND.NXT += consumption;
  - set `outstanding`; clear timer and retry count.
- ACK processing: `ack_in_valid` with `ack_in_num` == SND.NXT while `outstanding` sets SND.UNA = SND.NXT, clears `outstanding`, and stops the timer. Any other ack number is ignored.
- Timer: counts while `outstanding` and no header is pending. On reaching `RTO_CYCLES-1`:
  - if retry count < `MAX_RETRIES`: raise a retransmit request and increment the retry count;
  - otherwise: pulse `retx_fail`, clear `outstanding`, leave SND.NXT unchanged.
- Retransmit header: stored seq/flags/len; current `rcv_nxt`/`rcv_wnd`; `m_retx` = 1. The timer restarts from 0 when the header is accepted.
- RST acceptance clears `outstanding`.

## Timing
- Reset values: every output 0; SND.UNA = SND.NXT = 0; timer, retry count and pending retransmit all 0.
- Latency: a request accepted in cycle N gives `m_hdr_valid` = 1 in cycle N+1.
- Header fields hold stable until `m_hdr_valid && m_hdr_ready`. `m_hdr_valid` drops the following cycle; there is no back-to-back issue, so at most one header per 2 cycles.
- Updates in the acceptance cycle become visible the next cycle: SND.NXT and `outstanding` at N+1; the ack update of SND.UNA is likewise visible one cycle later.
- Simultaneous events:
  - ACK match and timeout in the same cycle: the ACK wins; no retransmit, no retry increment.
  - ACK match while a retransmit header is pending: the header still completes; `outstanding` is cleared.
  - `iss_load` with a request in the same cycle: `iss_load` wins; the request is not accepted that cycle.
  - `iss_load` does not cancel a pending header.
- Reset mid-handshake: `m_hdr_valid` drops immediately; the pending header is discarded.

## Configuration
- `TCP_TX_SCHED_RETX_EN` defined: timer, retry counter, retransmit store and `retx_fail` are implemented as described.
- Not defined:
  - no timer or store;
  - `outstanding` clears only by a matching ACK, RST or `iss_load`;
  - `m_retx` and `retx_fail` are tied 0;
  - `RTO_CYCLES` and `MAX_RETRIES` are unused.

## Test plan
- `iss_load` with `iss` = 0x1000, ctrl SYN -> `m_seq` = 0x1000, `m_syn` = 1; SND.NXT = 0x1001; `ack_in_num` = 0x1001 -> `outstanding` = 0, SND.UNA = 0x1001.
- Data len 100 at SND.NXT = 0x1001 while a pure ACK ctrl request is also valid -> ACK issued first with `m_seq` = 0x1001, `m_len` = 0; data follows with `m_len` = 100; SND.NXT = 0x1065.
- Outstanding data, no ACK, `RTO_CYCLES` = 50, `MAX_RETRIES` = 2 -> two headers with `m_retx` = 1, identical `m_seq`; `retx_fail` pulses once after the third timeout.
- SND.NXT = 0xFFFFFFF0, data len 0x20 -> SND.NXT = 0x00000010; ACK 0x00000010 clears `outstanding`.
- Timeout and matching ACK in the same cycle -> no retransmit header, retry count unchanged; `m_hdr_ready` held low for 10 cycles -> fields stable throughout.
- Built without `TCP_TX_SCHED_RETX_EN`, outstanding FIN, 10×`RTO_CYCLES` idle -> no retransmission, `outstanding` stays 1, `retx_fail` stays 0.
